// File: rtl/gf180mcu_fd_sc_mcu7t5v0__scan_unload_rdr.sv
`default_nettype none
// ============================================================================
// Module   : gf180mcu_fd_sc_mcu7t5v0__scan_unload_rdr
// Purpose  : Serial read-out engine for a bank of capture flops. On a capture
//            request the WIDTH-bit parallel word is snapshotted and shifted
//            out MSB-first over a single-bit valid/ready stream, optionally
//            followed by an even-parity bit.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   CLK       in   1      rising-edge clock
//   R         in   1      synchronous reset, active-high
//   CAP_REQ   in   1      capture request (honoured only when idle)
//   PI        in   WIDTH  parallel word to snapshot
//   CAP_ACK   out  1      one-cycle pulse: snapshot taken
//   SO        out  1      serial data bit (0 when SO_VALID=0)
//   SO_VALID  out  1      SO holds a valid bit
//   SO_READY  in   1      downstream accepts the current bit
//   SO_LAST   out  1      current bit is the final bit of the frame
//   BUSY      out  1      frame in progress
//   DONE      out  1      one-cycle pulse after the final bit is accepted
// ============================================================================
module gf180mcu_fd_sc_mcu7t5v0__scan_unload_rdr #(
  parameter int WIDTH     = 8,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic             CLK,
  input  logic             R,
  input  logic             CAP_REQ,
  input  logic [WIDTH-1:0] PI,
  output logic             CAP_ACK,
  output logic             SO,
  output logic             SO_VALID,
  input  logic             SO_READY,
  output logic             SO_LAST,
  output logic             BUSY,
  output logic             DONE
);

  // Counter reaches WIDTH after the last data bit, so it needs WIDTH+1 codes.
  localparam int               CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t           state, state_nxt;
  state_t           after_data;
  logic [WIDTH-1:0] shadow, shadow_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic             par, par_nxt;
  logic             cap_ack, cap_ack_nxt;
  logic             last_data;

  // Where the frame goes once the final data bit has been accepted.
  generate
    if (PARITY_EN) begin : g_par_on
      assign after_data = PAR;
    end else begin : g_par_off
      assign after_data = FIN;
    end
  endgenerate

  assign last_data = (count == LAST_IDX);

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (R) begin
      state   <= IDLE;
      shadow  <= '0;
      count   <= '0;
      par     <= 1'b0;
      cap_ack <= 1'b0;
    end else begin
      state   <= state_nxt;
      shadow  <= shadow_nxt;
      count   <= count_nxt;
      par     <= par_nxt;
      cap_ack <= cap_ack_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output decode
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt   = state;
    shadow_nxt  = shadow;
    count_nxt   = count;
    par_nxt     = par;
    cap_ack_nxt = 1'b0;
    SO          = 1'b0;
    SO_VALID    = 1'b0;
    SO_LAST     = 1'b0;
    DONE        = 1'b0;

    unique case (state)
      IDLE: begin
        if (CAP_REQ) begin
          shadow_nxt  = PI;
          count_nxt   = '0;
          par_nxt     = ^PI;
          cap_ack_nxt = 1'b1;
          state_nxt   = SHIFT;
        end
      end

      SHIFT: begin
        SO       = shadow[WIDTH-1];
        SO_VALID = 1'b1;
        // The last data bit closes the frame only when no parity follows.
        SO_LAST  = !PARITY_EN && last_data;
        if (SO_READY) begin
          shadow_nxt = {shadow[WIDTH-2:0], 1'b0};
          count_nxt  = count + 1'b1;
          if (last_data) begin
            state_nxt = after_data;
          end
        end
      end

      PAR: begin
        SO       = par;
        SO_VALID = 1'b1;
        SO_LAST  = 1'b1;
        if (SO_READY) begin
          state_nxt = FIN;
        end
      end

      FIN: begin
        DONE      = 1'b1;
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign CAP_ACK = cap_ack;
  assign BUSY    = (state != IDLE);

endmodule
`default_nettype wire
